// File: rtl/cell_hdr_rewriter.sv
// ATM UNI header stage: checks the received HEC, swaps in the VPI from the
// forwarding table, regenerates the HEC and hands the header to the switch core.
module cell_hdr_rewriter #(
    parameter int NumTx = 4,
    parameter int CntW  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_hdr,
    input  logic [7:0]        in_hec,
    output logic              lut_rd,
    output logic [7:0]        lut_addr,
    input  logic [NumTx+7:0]  lut_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_hdr,
    output logic [7:0]        out_hec,
    output logic [NumTx-1:0]  out_fwd,
    output logic [CntW-1:0]   hec_err_cnt,
    output logic [CntW-1:0]   nofwd_cnt
);

    typedef enum logic [1:0] {IDLE, LOOKUP, WAIT, OUTPUT} state_t;

    // CRC-8 (x^8+x^2+x+1), MSB first, zero init, coset 8'h55 applied at the end.
    function automatic logic [7:0] hec_calc(input logic [31:0] h);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 31; i >= 0; i--) begin
            fb = c[7] ^ h[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c ^ 8'h55;
    endfunction

    state_t state, state_nxt;

    // Only the fields that survive the rewrite are kept; the VPI lives in lut_addr.
    logic [3:0]       gfc_q;
    logic [19:0]      low_q;
    logic             hec_ok;
    logic [NumTx-1:0] lut_fwd;
    logic [7:0]       lut_vpi;
    logic [31:0]      new_hdr;
    logic [7:0]       new_hec;

    assign hec_ok  = (hec_calc(in_hdr) == in_hec);
    assign lut_fwd = lut_data[NumTx+7:8];
    assign lut_vpi = lut_data[7:0];
    assign new_hdr = {gfc_q, lut_vpi, low_q};
    assign new_hec = hec_calc(new_hdr);

    assign in_ready  = (state == IDLE);
    assign lut_rd    = (state == LOOKUP);
    assign out_valid = (state == OUTPUT);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid && hec_ok) state_nxt = LOOKUP;
            LOOKUP:  state_nxt = WAIT;
            WAIT:    state_nxt = (lut_fwd == '0) ? IDLE : OUTPUT;
            OUTPUT:  if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            gfc_q       <= '0;
            low_q       <= '0;
            lut_addr    <= '0;
            out_hdr     <= '0;
            out_hec     <= '0;
            out_fwd     <= '0;
            hec_err_cnt <= '0;
            nofwd_cnt   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid && hec_ok) begin
                        gfc_q    <= in_hdr[31:28];
                        low_q    <= in_hdr[19:0];
                        lut_addr <= in_hdr[27:20];
                    end else if (in_valid && (hec_err_cnt != '1)) begin
                        hec_err_cnt <= hec_err_cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (lut_fwd == '0) begin
                        if (nofwd_cnt != '1) nofwd_cnt <= nofwd_cnt + 1'b1;
                    end else begin
                        out_hdr <= new_hdr;
                        out_hec <= new_hec;
                        out_fwd <= lut_fwd;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/cell_hdr_rewriter.md
Name: cell_hdr_rewriter

Overview:
- Per-port ATM UNI header stage that sits directly upstream of the forwarding/rewrite lookup table interface.
- Accepts a received 5-byte cell header and verifies its HEC.
- Reads the table entry indexed by the incoming VPI, substitutes the new VPI and regenerates HEC.
- Presents the rewritten header plus the forwarding port mask to the switch core; drops errored or unrouted cells and counts them.

Parameters:
- NumTx, 4, number of transmit ports; width of the forwarding mask.
- CntW, 16, width of the saturating drop/error counters.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input header valid.
- in_ready  out  1  block can accept a header.
- in_hdr  in  32  {GFC[31:28], VPI[27:20], VCI[19:4], PT[3:1], CLP[0]}.
- in_hec  in  8  received HEC byte.
- lut_rd  out  1  one-cycle table read strobe.
- lut_addr  out  8  table address (= incoming VPI).
- lut_data  in  NumTx+8  {fwd[NumTx-1:0], new_vpi[7:0]}; valid exactly 1 cycle after lut_rd.
- out_valid  out  1  rewritten header valid.
- out_ready  in  1  downstream accepts.
- out_hdr  out  32  rewritten header.
- out_hec  out  8  regenerated HEC.
- out_fwd  out  NumTx  forwarding port mask.
- hec_err_cnt  out  CntW  headers dropped for bad HEC (saturating).
- nofwd_cnt  out  CntW  headers dropped for fwd==0 (saturating).

Behaviour:
- Clocking/reset: one clock `clk`; reset `rst` is synchronous, active-high.
- Reset values:
  - State IDLE; in_ready=1; all other outputs 0.
  - Counters 0.
  - Reset mid-operation abandons the held header with no output and no count. A lut_data return arriving the cycle after reset is ignored.
- HEC: CRC-8, polynomial x^8+x^2+x+1, init 0, over 4 header bytes MSB first, result XOR 8'h55 (ITU I.432). No single-bit correction.
- FSM states IDLE, LOOKUP, WAIT, OUTPUT:
  - IDLE: in_ready=1. On in_valid, capture hdr/hec.
    - If computed HEC != in_hec: increment hec_err_cnt, stay IDLE.
    - Otherwise go to LOOKUP.
  - LOOKUP: in_ready=0; lut_rd=1 for exactly this cycle; lut_addr=captured VPI; go to WAIT.
  - WAIT: register lut_data.
    - fwd==0: increment nofwd_cnt, go to IDLE.
    - Otherwise build the header with VPI replaced (GFC, VCI, PT, CLP unchanged), compute the HEC combinationally from the rewritten header, and go to OUTPUT.
  - OUTPUT: out_valid=1. out_hdr/out_hec/out_fwd stay stable until out_ready=1, then go to IDLE; out_valid drops the next cycle.
- Latency and throughput: header accepted at edge T gives lut_rd in cycle T+1 and out_valid from cycle T+3. Minimum 4 cycles per cell when out_ready is held high. No overlap; in_ready=0 in LOOKUP/WAIT/OUTPUT.
- lut_addr holds its value outside LOOKUP; lut_rd is never asserted twice per cell.
- Counters saturate at 2^CntW-1 and never wrap. Both counters cannot increment in the same cycle (different states).
- Same-VPI rewrite (new_vpi == old) is legal; the output HEC equals the input HEC.

Test Plan:
- hdr=32'h0000_0000, hec=8'h55; LUT[0]={4'b0011, 8'h12}:
  - lut_rd in cycle T+1 with lut_addr=0.
  - out_valid at T+3 with out_hdr=32'h0120_0000, out_hec=8'h00, out_fwd=4'b0011.
- Same header with hec=8'h54 -> no lut_rd, no out_valid, hec_err_cnt=1, in_ready stays 1.
- hdr=32'h0050_0000 (VPI 5), valid HEC, LUT[5] fwd=0 -> one lut_rd with lut_addr=5, no out_valid, nofwd_cnt=1.
- Valid cell with out_ready held low 10 cycles -> out_valid and all output fields stable for 10 cycles; in_ready=0 throughout; release gives one transfer, then in_ready=1.
- Assert rst in WAIT, then deassert -> no out_valid, counters 0; next valid cell (hdr=0, hec=55) is processed normally.
- Preload hec_err_cnt via 65537 bad-HEC headers -> counter reads 16'hFFFF, not 0.
